// File: rtl/program_counter.sv
// Fetch-stage program counter: increment, branch, jump, call/return via a
// return-address stack (RAS enabled by PROGRAM_COUNTER_RAS_EN).
// Ports: clk, reset_n (async low); stall; br_taken/br_offset; jump/jump_addr;
// call; ret -> pc, pc_plus_one, ras_empty, ras_full, ras_err.
module program_counter #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_one,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [WIDTH-1:0] pc_n;

  assign pc_plus_one = pc + WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= pc_n;
  end

`ifdef PROGRAM_COUNTER_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [CW-1:0]    count;
  logic [AW-1:0]    top;
  logic             push;
  logic             pop;
  logic             err_n;
  logic             err_q;

  // Low bits of count address the free slot; one below is the top entry.
  assign top = count[AW-1:0] - AW'(1);

  always_comb begin
    pc_n  = pc_plus_one;
    push  = 1'b0;
    pop   = 1'b0;
    err_n = 1'b0;
    if (stall) begin
      pc_n = pc;
    end else if (ret) begin
      if (count != '0) begin
        pc_n = stack[top];
        pop  = 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end else if (call) begin
      pc_n = jump_addr;
      if (count == FULL) err_n = 1'b1;
      else               push  = 1'b1;
    end else if (jump) begin
      pc_n = jump_addr;
    end else if (br_taken) begin
      pc_n = pc + br_offset;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_n;
      if (push)     count <= count + CW'(1);
      else if (pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      stack[count[AW-1:0]] <= pc_plus_one;
    end
  end

  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL);
  assign ras_err   = err_q;
`else
  // Without a stack, call degenerates to jump and ret to increment.
  always_comb begin
    pc_n = pc_plus_one;
    if (stall)         pc_n = pc;
    else if (ret)      pc_n = pc_plus_one;
    else if (call)     pc_n = jump_addr;
    else if (jump)     pc_n = jump_addr;
    else if (br_taken) pc_n = pc + br_offset;
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed spot checks plus
// randomized commands against a queue-based reference model.
module tb_program_counter;

`ifdef PROGRAM_COUNTER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, br_taken, jump, call, ret;
  logic [15:0] br_offset, jump_addr;
  logic [15:0] pc, pc_plus_one;
  logic        ras_empty, ras_full, ras_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stack [$];
  logic        m_err;

  program_counter #(.WIDTH(16), .RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_addr(jump_addr),
    .call(call), .ret(ret),
    .pc(pc), .pc_plus_one(pc_plus_one),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  // Reference behaviour of one clock edge given the applied commands.
  task automatic model_step();
    m_err = 1'b0;
    if (stall) return;
    if (ret) begin
      if (RAS_EN && m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc = m_pc + 16'd1;
        m_err = RAS_EN;
      end
    end else if (call) begin
      if (RAS_EN) begin
        if (m_stack.size() < 4) m_stack.push_back(m_pc + 16'd1);
        else m_err = 1'b1;
      end
      m_pc = jump_addr;
    end else if (jump) m_pc = jump_addr;
    else if (br_taken) m_pc = m_pc + br_offset;
    else m_pc = m_pc + 16'd1;
  endtask

  task automatic compare();
    chk("pc", pc, m_pc);
    chk("pc_plus_one", pc_plus_one, m_pc + 16'd1);
    chk("ras_empty", 16'(ras_empty), 16'(RAS_EN ? (m_stack.size() == 0) : 1'b1));
    chk("ras_full", 16'(ras_full), 16'(RAS_EN ? (m_stack.size() == 4) : 1'b0));
    chk("ras_err", 16'(ras_err), 16'(m_err));
  endtask

  task automatic cyc(input logic s, input logic b, input logic [15:0] off,
                     input logic j, input logic [15:0] ja,
                     input logic c, input logic r);
    stall = s; br_taken = b; br_offset = off;
    jump = j; jump_addr = ja; call = c; ret = r;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 0, 16'h0, 0, 0);
  endtask

  task automatic go(input logic [15:0] a);
    cyc(0, 0, 16'h0, 1, a, 0, 0);
  endtask

  logic [15:0] exp_ret [4];

  initial begin
    reset_n = 1'b0;
    stall = 0; br_taken = 0; br_offset = '0;
    jump = 0; jump_addr = '0; call = 0; ret = 0;
    model_reset();
    #3;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_empty", 16'(ras_empty), 16'h1);
    chk("rst_full", 16'(ras_full), 16'h0);
    chk("rst_err", 16'(ras_err), 16'h0);
    #4 reset_n = 1'b1;

    // Wrap at the top of the address space.
    go(16'hFFFE);
    chk("lit_fffe", pc, 16'hFFFE);
    idle();
    chk("lit_ffff", pc, 16'hFFFF);
    chk("lit_ppo_wrap", pc_plus_one, 16'h0000);
    idle();
    chk("lit_wrap0", pc, 16'h0000);
    idle();
    chk("lit_wrap1", pc, 16'h0001);

    // Negative branch, then jump beating branch.
    go(16'h0010);
    cyc(0, 1, 16'hFFF0, 0, 16'h0, 0, 0);
    chk("lit_br_neg", pc, 16'h0000);
    go(16'h0010);
    cyc(0, 1, 16'hFFF0, 1, 16'h0200, 0, 0);
    chk("lit_jmp_pri", pc, 16'h0200);

    // Call then return.
    go(16'h0100);
    cyc(0, 0, 16'h0, 0, 16'h0400, 1, 0);
    chk("lit_call", pc, 16'h0400);
    chk("lit_call_empty", 16'(ras_empty), 16'(!RAS_EN));
    cyc(0, 0, 16'h0, 0, 16'h0, 0, 1);
    chk("lit_ret", pc, RAS_EN ? 16'h0101 : 16'h0401);
    chk("lit_ret_empty", 16'(ras_empty), 16'h1);
    chk("lit_ret_err", 16'(ras_err), 16'h0);

    // Overflow and underflow of the stack.
    exp_ret = '{16'h0041, 16'h0031, 16'h0021, 16'h0011};
    for (int i = 0; i < 5; i++) begin
      go(16'(16 * (i + 1)));
      cyc(0, 0, 16'h0, 0, 16'h0800 + 16'(i), 1, 0);
    end
    chk("lit_ovf_err", 16'(ras_err), 16'(RAS_EN));
    chk("lit_ovf_full", 16'(ras_full), 16'(RAS_EN));
    idle();
    chk("lit_err_pulse", 16'(ras_err), 16'h0);
    go(16'h0011);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'h0, 0, 16'h0, 0, 1);
      if (RAS_EN) chk("lit_lifo", pc, exp_ret[i]);
    end
    go(16'h0011);
    cyc(0, 0, 16'h0, 0, 16'h0, 0, 1);
    chk("lit_unf_pc", pc, 16'h0012);
    chk("lit_unf_err", 16'(ras_err), 16'(RAS_EN));

    // Stall swallows a call, both with empty and non-empty stack.
    go(16'h0300);
    cyc(1, 0, 16'h0, 0, 16'h0400, 1, 0);
    chk("lit_stall_pc", pc, 16'h0300);
    chk("lit_stall_empty", 16'(ras_empty), 16'h1);
    cyc(0, 0, 16'h0, 0, 16'h0400, 1, 0);
    cyc(1, 0, 16'h0, 0, 16'h0500, 1, 1);
    chk("lit_stall2_pc", pc, 16'h0400);

    // Asynchronous reset mid-cycle with live stack contents.
    go(16'h0123);
    #2 reset_n = 1'b0;
    #1;
    chk("lit_async_pc", pc, 16'h0000);
    chk("lit_async_empty", 16'(ras_empty), 16'h1);
    model_reset();
    #1 reset_n = 1'b1;
    idle();

    // Randomized commands.
    for (int n = 0; n < 3000; n++) begin
      logic s, b, j, c, r;
      s = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 6) == 0);
      c = ($urandom_range(0, 5) == 0);
      j = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 2) == 0);
      cyc(s, b, 16'($urandom), j, 16'($urandom), c, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
